// File: rtl/spec_pkg.sv
// Shared definitions for the spectrum path: frame sequencer state encoding and
// default transform size, also used by the window and sqrlog blocks.
package spec_pkg;

  localparam int FFT_LEN_DEF = 8192;
  localparam int IDX_W_DEF   = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: cuts the decimated sample stream into FFT_LEN frames, drives the
// sink handshake and window index, and waits for each FFT output frame before the next.
module fft_frame_ctrl
  import spec_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             fft_clk,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic             ctrl_continuous,
  input  logic             ctrl_stop,
  input  logic [7:0]       frame_cfg,
  input  logic             sample_valid,
  input  logic             sink_ready,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  output logic [IDX_W-1:0] win_addr,
  input  logic             fft_out_eop,
  output logic             busy,
  output logic [CNT_W-1:0] frames_done,
  output logic             overrun,
  output logic [1:0]       dbg_state_o
);

  // Sink handshake: a beat is transferred in cycle n+1 (sink_valid high) for every
  // sample_valid seen in cycle n while sink_ready was high; sink_valid is never held
  // waiting for ready, so a sample that meets ready low is dropped and flagged.

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       rem_q, rem_d;
  logic             cont_q, cont_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             ovr_q, ovr_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             busy_q, busy_d;
  logic             last_idx;

  assign last_idx = (idx_q == IDX_W'(FFT_LEN - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    cont_d   = cont_q;
    stop_d   = stop_q;
    frames_d = frames_q;
    ovr_d    = ovr_q;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    addr_d   = addr_q;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous ctrl_stop is ignored here: start wins.
        if (ctrl_start) begin
          state_d  = ST_ARM;
          cont_d   = ctrl_continuous;
          rem_d    = (frame_cfg == 8'd0) ? 8'd1 : frame_cfg;
          frames_d = '0;
          ovr_d    = 1'b0;
          stop_d   = 1'b0;
          idx_d    = '0;
        end
      end
      ST_ARM: begin
        if (ctrl_stop) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end else if (sink_ready) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end
      end
      ST_STREAM: begin
        if (ctrl_stop) stop_d = 1'b1;
        if (sample_valid) begin
          if (sink_ready) begin
            valid_d = 1'b1;
            sop_d   = (idx_q == '0);
            eop_d   = last_idx;
            addr_d  = idx_q;
            idx_d   = idx_q + 1'b1;
            if (last_idx) state_d = ST_DRAIN;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (ctrl_stop) stop_d = 1'b1;
        if (fft_out_eop) begin
          frames_d = frames_q + 1'b1;
          if (!cont_q) rem_d = rem_q - 8'd1;
          if (stop_q || ctrl_stop) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else if (!cont_q && rem_q == 8'd1) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge fft_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      cont_q   <= 1'b0;
      stop_q   <= 1'b0;
      frames_q <= '0;
      ovr_q    <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      cont_q   <= cont_d;
      stop_q   <= stop_d;
      frames_q <= frames_d;
      ovr_q    <= ovr_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
    end
  end

  assign sink_valid  = valid_q;
  assign sink_sop    = sop_q;
  assign sink_eop    = eop_q;
  assign win_addr    = addr_q;
  assign busy        = busy_q;
  assign frames_done = frames_q;
  assign overrun     = ovr_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the spectrum path on `fft_clk`. It takes the decimated sample strobe, cuts the stream into FFT_LEN-sample frames, and drives the window and FFT sink handshake (valid/sop/eop plus window coefficient index). It waits for the FFT output frame to complete before starting the next one, and reports frame count and overrun status to the control side.

## Interface
Parameters:
- FFT_LEN, 8192: samples per frame; must be a power of two, at least 4.
- IDX_W, 13: width of the sample index; log2(FFT_LEN).
- CNT_W, 16: width of the frames_done counter.

Ports:
- fft_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- ctrl_start  in  1  single-cycle pulse that begins an acquisition. Ignored unless the block is in IDLE.
- ctrl_continuous  in  1  sampled at start. 1 = run until ctrl_stop; 0 = run frame_cfg frames.
- ctrl_stop  in  1  pulse requesting a graceful stop at the end of the current frame.
- frame_cfg  in  8  number of frames in single-shot mode; 0 is treated as 1.
- sample_valid  in  1  one-cycle strobe marking a new decimated sample.
- sink_ready  in  1  FFT sink ready.
- sink_valid  out  1  sample accepted into the frame.
- sink_sop  out  1  first sample of the frame.
- sink_eop  out  1  last sample of the frame.
- win_addr  out  IDX_W  index of the current sample in the frame; addresses the window ROM.
- fft_out_eop  in  1  FFT source eop, qualified by source valid and ready.
- busy  out  1  high in any state other than IDLE.
- frames_done  out  CNT_W  completed output frames since start; wraps at its maximum.
- overrun  out  1  sticky flag: a sample arrived while it could not be accepted.

## Operation
- States: IDLE, ARM, STREAM, DRAIN.
- IDLE:
  - ctrl_start → ARM.
  - On entry to ARM: latch ctrl_continuous, load remaining = max(frame_cfg, 1), clear frames_done and overrun.
- ARM: wait for sink_ready high, then go to STREAM with idx = 0.
- STREAM, on each sample_valid:
  - If sink_ready = 1: emit the sample.
    - sink_valid = 1, win_addr = idx.
    - sink_sop = (idx == 0), sink_eop = (idx == FFT_LEN-1).
    - Increment idx.
  - If sink_ready = 0: drop the sample. Set overrun, hold idx, emit nothing.
  - After the sample with idx = FFT_LEN-1 is emitted: go to DRAIN, idx wraps to 0.
- DRAIN: ignore sample_valid; samples arriving here are not counted as overrun.
- DRAIN, on fft_out_eop:
  - Increment frames_done.
  - Decrement remaining, unless in continuous mode.
  - Next state, in priority order:
    1. stop_pending = 1 → IDLE.
    2. Single-shot mode and remaining reaches 0 → IDLE.
    3. Otherwise → ARM.
- stop_pending:
  - Set by ctrl_stop in ARM, STREAM or DRAIN; cleared on entry to IDLE.
  - ctrl_stop in ARM → IDLE directly; no partial frame is produced.
  - ctrl_stop in STREAM → the current frame still completes and drains.
- At most one frame is in flight inside the FFT at any time.
- ctrl_start in the same cycle as ctrl_stop while in IDLE: start wins; the stop is ignored.
- fft_out_eop outside DRAIN is ignored.

## Timing
- All outputs are registered.
- Reset values: sink_valid, sink_sop, sink_eop, busy and overrun = 0; win_addr = 0; frames_done = 0; state = IDLE.
- Reset mid-frame aborts immediately. No eop is emitted; the downstream FFT is reset by the same signal.
- Latency: sample_valid in cycle n → sink_valid/sop/eop/win_addr in cycle n+1.
  - The data path delays samples by one cycle to stay aligned.
- sink_valid is asserted only when sink_ready was high in cycle n.
  - sink_ready falling in cycle n+1 does not retract the beat; the FFT sink accepts one beat after ready deasserts.
- busy:
  - Rises the cycle after ctrl_start.
  - Falls the cycle after the terminating fft_out_eop, or after ctrl_stop when in ARM.
- frames_done updates the cycle after fft_out_eop.
- overrun sets the cycle after the dropped sample.
- Index arithmetic is unsigned modulo FFT_LEN; eop is decoded from idx == FFT_LEN-1.

## Structure
- Shared package spec_pkg holds:
  - the state enum (IDLE/ARM/STREAM/DRAIN);
  - default FFT_LEN/IDX_W constants, shared with the window and sqrlog blocks.
- Single module; no sub-module. The idx counter and FSM live together.

## Test plan
Benches run with FFT_LEN = 8.
- Single-shot:
  - Stimulus: frame_cfg = 2, sample_valid every 3rd cycle, sink_ready = 1, fft_out_eop 20 cycles after each eop.
  - Response: two frames of 8 beats, win_addr 0..7, sop on idx 0 and eop on idx 7; frames_done = 2; busy falls; overrun = 0.
- Backpressure:
  - Stimulus: sink_ready low for the 4th sample.
  - Response: overrun = 1; that sample is dropped; idx stays 3 and the next accepted sample carries win_addr = 3; the frame still has exactly 8 beats.
- Continuous with stop:
  - Stimulus: ctrl_continuous = 1, ctrl_stop pulsed mid-frame 3.
  - Response: frame 3 completes 8 beats; IDLE after its fft_out_eop; frames_done = 3.
- Stop in ARM:
  - Stimulus: sink_ready held low after start, ctrl_stop pulsed.
  - Response: IDLE with no beats emitted; frames_done = 0.
- Reset mid-STREAM:
  - Stimulus: reset asserted at idx 5.
  - Response: all outputs 0 the next cycle; a following ctrl_start restarts at idx 0.
- Edge cases:
  - frame_cfg = 0 → exactly 1 frame.
  - ctrl_start while busy → ignored; frames_done is not cleared.
